// File: rtl/hc_pkg.sv
// Shared definitions for the hc_univ_reg register family: mode encoding
// for the S select input of the universal register.
package hc_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHU  = 2'b01,
      MODE_SHD  = 2'b10,
      MODE_LOAD = 2'b11
   } hc_mode_e;

endpackage : hc_pkg

// File: rtl/hc_dff_cell.sv
// One bit of the universal register: an HC74-style D flip-flop with
// synchronous reset, active-low set/clear (with the both-high conflict
// state on QN) and clock enable. The mode-selected next data comes from
// the top level.
module hc_dff_cell (
   input  logic CP,
   input  logic RD,
   input  logic RST,
   input  logic CE,
   input  logic NXT,
   input  logic SDN,
   input  logic RDN,
   output logic Q,
   output logic QN
);

   logic q_r;
   logic qn_r;
   logic q_nxt_s;
   logic qn_nxt_s;

   // Priority resolution: reset, set/clear conflict, set, clear, enable, mode data.
   always_comb begin
      q_nxt_s  = q_r;
      qn_nxt_s = ~q_r;
      if (RD) begin
         q_nxt_s  = RST;
         qn_nxt_s = ~RST;
      end else if (!SDN && !RDN) begin
         // Both asserted: reproduce the HC74 state with both outputs high.
         q_nxt_s  = 1'b1;
         qn_nxt_s = 1'b1;
      end else if (!SDN) begin
         q_nxt_s  = 1'b1;
         qn_nxt_s = 1'b0;
      end else if (!RDN) begin
         q_nxt_s  = 1'b0;
         qn_nxt_s = 1'b1;
      end else if (!CE) begin
         // Hold Q; QN is re-derived so a bit leaving conflict becomes ~Q.
         q_nxt_s  = q_r;
         qn_nxt_s = ~q_r;
      end else begin
         q_nxt_s  = NXT;
         qn_nxt_s = ~NXT;
      end
   end

   // State register for the true and complement outputs.
   always_ff @(posedge CP) begin
      q_r  <= q_nxt_s;
      qn_r <= qn_nxt_s;
   end

   assign Q  = q_r;
   assign QN = qn_r;

endmodule : hc_dff_cell

// File: rtl/hc_univ_reg_chk.sv
// Protocol checker for hc_univ_reg: the mode select must be known whenever
// it is actually used (enabled and not in reset).
module hc_univ_reg_chk (
   input logic       CP,
   input logic       RD,
   input logic       CE,
   input logic [1:0] S
);

   a_mode_known : assert property (@(posedge CP) disable iff (RD) CE |-> !$isunknown(S));

endmodule : hc_univ_reg_chk

// File: rtl/hc_univ_reg.sv
// WIDTH-bit 74HC194-style universal register built from HC74-style cells:
// hold, shift up, shift down and parallel load with clock enable and
// per-bit synchronous set/clear.
module hc_univ_reg
   import hc_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             CP,
   input  logic             RD,
   input  logic             CE,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] D,
   input  logic             DSU,
   input  logic             DSD,
   input  logic [WIDTH-1:0] SDN,
   input  logic [WIDTH-1:0] RDN,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   output logic             SOU,
   output logic             SOD
);

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] qn_s;
   logic [WIDTH-1:0] nxt_s;

   // Mode mux: shift sources are the pre-edge Q, conflict bits included.
   always_comb begin
      nxt_s = q_s;
      case (S)
         MODE_HOLD: nxt_s = q_s;
         MODE_SHU:  nxt_s = {q_s[WIDTH-2:0], DSU};
         MODE_SHD:  nxt_s = {DSD, q_s[WIDTH-1:1]};
         MODE_LOAD: nxt_s = D;
         default:   nxt_s = q_s;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      hc_dff_cell u_cell (
         .CP  (CP),
         .RD  (RD),
         .RST (RST_VAL[i]),
         .CE  (CE),
         .NXT (nxt_s[i]),
         .SDN (SDN[i]),
         .RDN (RDN[i]),
         .Q   (q_s[i]),
         .QN  (qn_s[i])
      );
   end

   hc_univ_reg_chk u_chk (
      .CP (CP),
      .RD (RD),
      .CE (CE),
      .S  (S)
   );

   assign Q   = q_s;
   assign QN  = qn_s;
   assign SOU = q_s[WIDTH-1];
   assign SOD = q_s[0];

endmodule : hc_univ_reg

// File: tb/tb_hc_univ_reg.sv
// Self-checking bench for hc_univ_reg (WIDTH=8, RST_VAL=0): a table of
// input/expected records plus hand-written corner sequences, checked
// through a scoreboard queue one edge after each stimulus is applied.
module tb_hc_univ_reg;

   logic       CP;
   logic       RD;
   logic       CE;
   logic [1:0] S;
   logic [7:0] D;
   logic       DSU;
   logic       DSD;
   logic [7:0] SDN;
   logic [7:0] RDN;
   logic [7:0] Q;
   logic [7:0] QN;
   logic       SOU;
   logic       SOD;

   hc_univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .CP  (CP),
      .RD  (RD),
      .CE  (CE),
      .S   (S),
      .D   (D),
      .DSU (DSU),
      .DSD (DSD),
      .SDN (SDN),
      .RDN (RDN),
      .Q   (Q),
      .QN  (QN),
      .SOU (SOU),
      .SOD (SOD)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   typedef struct {
      logic       rd;
      logic       ce;
      logic [1:0] s;
      logic [7:0] d;
      logic       dsu;
      logic       dsd;
      logic [7:0] sdn;
      logic [7:0] rdn;
      logic [7:0] eq;
      logic [7:0] eqn;
   } vec_t;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic [7:0] qn;
      logic [7:0] conf;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[20];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rd, input logic ce, input logic [1:0] s,
                               input logic [7:0] d, input logic dsu, input logic dsd,
                               input logic [7:0] sdn, input logic [7:0] rdn,
                               input logic [7:0] eq, input logic [7:0] eqn);
      vec_t v;
      v.rd = rd; v.ce = ce; v.s = s; v.d = d; v.dsu = dsu; v.dsd = dsd;
      v.sdn = sdn; v.rdn = rdn; v.eq = eq; v.eqn = eqn;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one record, push its expectation, then compare one edge later.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge CP);
      RD = v.rd; CE = v.ce; S = v.s; D = v.d; DSU = v.dsu; DSD = v.dsd;
      SDN = v.sdn; RDN = v.rdn;
      e.tag  = tag;
      e.q    = v.eq;
      e.qn   = v.eqn;
      e.conf = v.rd ? 8'h00 : (~v.sdn & ~v.rdn);
      sb.push_back(e);
      @(posedge CP);
      #1;
      e = sb.pop_front();
      check({e.tag, " Q"}, Q, e.q);
      check({e.tag, " QN"}, QN, e.qn);
      check({e.tag, " SOU"}, {7'd0, SOU}, {7'd0, e.q[7]});
      check({e.tag, " SOD"}, {7'd0, SOD}, {7'd0, e.q[0]});
      // Outside conflict bits the outputs must be exact complements.
      check({e.tag, " QN==~Q"}, (Q ~^ QN) & ~e.conf, 8'h00);
   endtask

   initial begin
      RD = 1'b1; CE = 1'b1; S = 2'b00; D = 8'h00; DSU = 1'b0; DSD = 1'b0;
      SDN = 8'hFF; RDN = 8'hFF;

      //            rd    ce    s      d      dsu   dsd   sdn    rdn    Q      QN
      tbl[0]  = mk(1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF);
      tbl[1]  = mk(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hA5, 8'h5A);
      tbl[2]  = mk(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h81, 8'h7E);
      tbl[3]  = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h03, 8'hFC);
      tbl[4]  = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h07, 8'hF8);
      tbl[5]  = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h0F, 8'hF0);
      tbl[6]  = mk(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h81, 8'h7E);
      tbl[7]  = mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h40, 8'hBF);
      tbl[8]  = mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h20, 8'hDF);
      tbl[9]  = mk(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF);
      tbl[10] = mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFE, 8'hFE, 8'h01, 8'hFF);
      tbl[11] = mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE);
      tbl[12] = mk(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      // Clear on bits 3:0 applies with CE=0; the blocked load is then shown with D=00.
      tbl[13] = mk(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hF0, 8'hF0, 8'h0F);
      tbl[14] = mk(1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hF0, 8'h0F);
      tbl[15] = mk(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h3C, 8'hC3);
      tbl[16] = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h78, 8'h87);
      tbl[17] = mk(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF);
      tbl[18] = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE);
      tbl[19] = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h02, 8'hFD);

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // Conflict held across CE=0 edges, then released while still disabled.
      apply(mk(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF), "ceconf_ld");
      apply(mk(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h80, 8'hFF), "ceconf_1");
      apply(mk(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h80, 8'hFF), "ceconf_2");
      apply(mk(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h80, 8'h7F), "ceconf_rel");

      // A conflict bit (Q=1) is a valid shift source on the following edge.
      apply(mk(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF), "shconf_ld");
      apply(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'hFE, 8'hFE, 8'h01, 8'hFF), "shconf_1");
      apply(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h02, 8'hFD), "shconf_2");

      // Set on one bit while the rest shift down with DSD=1.
      apply(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 8'hBF, 8'hFF, 8'hC1, 8'h3E), "shd_set");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_hc_univ_reg
